// File: rtl/slg46620_cnt0_pkg.sv
// Shared types for the SLG46620 CNT0 counter/delay macrocell model:
// edge qualification, function select and delay/one-shot FSM state.
package slg46620_cnt0_pkg;

   typedef enum logic [1:0] {
      Rising_Edge  = 2'd0,
      Falling_Edge = 2'd1,
      Both_Edge    = 2'd2
   } edge_sel_e;

   typedef enum logic [1:0] {
      Delay       = 2'd0,
      One_Shot    = 2'd1,
      Edge_Detect = 2'd2
   } func_sel_e;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   // The reserved function code falls back to Delay.
   function automatic func_sel_e decode_func(input logic [1:0] code);
      case (code)
         2'd1:    return One_Shot;
         2'd2:    return Edge_Detect;
         default: return Delay;
      endcase
   endfunction

endpackage

// File: rtl/edge_sel_detect.sv
// Input register plus rise/fall detection and edge qualification for the
// selected edge mode.
module edge_sel_detect
   import slg46620_cnt0_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_in,
   input  logic [1:0] i_edge_sel,
   output logic       o_rise,
   output logic       o_fall,
   output logic       o_q
);

   logic r_in;

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) r_in <= 1'b0;
      else            r_in <= i_in;
   end

   assign o_rise = i_in & ~r_in;
   assign o_fall = ~i_in & r_in;

   // The unused edge code qualifies both edges.
   always_comb begin
      o_q = o_rise | o_fall;
      case (i_edge_sel)
         Rising_Edge:  o_q = o_rise;
         Falling_Edge: o_q = o_fall;
         default:      o_q = o_rise | o_fall;
      endcase
   end

endmodule

// File: rtl/dly_oneshot_macro.sv
// Delay / one-shot / edge-detect macrocell function with a saturating
// counter and a two-state FSM.
module dly_oneshot_macro
   import slg46620_cnt0_pkg::*;
#(
   parameter int BIT_WIDTH = 14
) (
   input  logic                 i_clk,
   input  logic                 i_reset_n,
   input  logic [BIT_WIDTH-1:0] i_data_from_register,
   input  logic [1:0]           i_edge_reset_mode_select,
   input  logic [1:0]           i_function_select,
   input  logic                 i_in,
   output logic                 o_out,
   output logic                 o_busy,
   output logic [BIT_WIDTH-1:0] o_count
);

   state_e               state;
   logic [BIT_WIDTH-1:0] cnt;
   logic                 target;
   logic                 out_q;
   logic [1:0]           fsel_q;
   logic [1:0]           esel_q;
   logic                 rise, fall, q;
   logic                 cfg_chg;
   logic                 at_end;
   func_sel_e            mode;

   edge_sel_detect u_edge (
      .i_clk      (i_clk),
      .i_reset_n  (i_reset_n),
      .i_in       (i_in),
      .i_edge_sel (i_edge_reset_mode_select),
      .o_rise     (rise),
      .o_fall     (fall),
      .o_q        (q)
   );

   assign mode    = decode_func(i_function_select);
   assign cfg_chg = (fsel_q != i_function_select) || (esel_q != i_edge_reset_mode_select);
   // Compare with >= so a shrinking D mid-run still terminates instead of wrapping.
   assign at_end  = (cnt >= i_data_from_register);

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state  <= IDLE;
         cnt    <= '0;
         target <= 1'b0;
         out_q  <= 1'b0;
         fsel_q <= i_function_select;
         esel_q <= i_edge_reset_mode_select;
      end else begin
         fsel_q <= i_function_select;
         esel_q <= i_edge_reset_mode_select;
         if (cfg_chg) begin
            state <= IDLE;
            cnt   <= '0;
            out_q <= (mode == Delay) ? i_in : 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (mode == Delay) begin
                     if (q && (i_data_from_register != '0)) begin
                        target <= i_in;
                        cnt    <= BIT_WIDTH'(1);
                        state  <= RUN;
                     end else if (rise | fall) begin
                        // o_out already equals r_in here; only a transition moves it.
                        out_q <= i_in;
                     end
                  end else if (q) begin
                     out_q <= 1'b1;
                     cnt   <= '0;
                     state <= RUN;
                  end
               end
               RUN: begin
                  if (mode == Delay) begin
                     if (i_in != target) begin
                        state <= IDLE;
                        cnt   <= '0;
                     end else if (at_end) begin
                        out_q <= target;
                        state <= IDLE;
                        cnt   <= '0;
                     end else begin
                        cnt <= cnt + 1'b1;
                     end
                  end else if ((mode == Edge_Detect) && q) begin
                     cnt <= '0;
                  end else if (at_end) begin
                     out_q <= 1'b0;
                     state <= IDLE;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign o_out   = out_q;
   assign o_busy  = (state == RUN);
   assign o_count = cnt;

endmodule

// File: tb/tb_dly_oneshot_macro.sv
// Directed bench for dly_oneshot_macro: a W=14 instance for the mode tests
// and a W=4 instance for the full-range pulse.
module tb_dly_oneshot_macro;
   import slg46620_cnt0_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [13:0] a_d;
   logic [1:0]  a_esel, a_fsel;
   logic        a_in, a_out, a_busy;
   logic [13:0] a_count;
   logic [3:0]  b_d;
   logic [1:0]  b_esel, b_fsel;
   logic        b_in, b_out, b_busy;
   logic [3:0]  b_count;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dly_oneshot_macro #(.BIT_WIDTH(14)) u_a (
      .i_clk(clk), .i_reset_n(rst_n), .i_data_from_register(a_d),
      .i_edge_reset_mode_select(a_esel), .i_function_select(a_fsel),
      .i_in(a_in), .o_out(a_out), .o_busy(a_busy), .o_count(a_count)
   );

   dly_oneshot_macro #(.BIT_WIDTH(4)) u_b (
      .i_clk(clk), .i_reset_n(rst_n), .i_data_from_register(b_d),
      .i_edge_reset_mode_select(b_esel), .i_function_select(b_fsel),
      .i_in(b_in), .o_out(b_out), .o_busy(b_busy), .o_count(b_count)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(input logic [1:0] f, input logic [1:0] e, input logic [13:0] d);
      a_fsel = f;
      a_esel = e;
      a_d    = d;
      repeat (3) tick();
   endtask

   logic [5:0] os_drv, os_exp;

   initial begin
      rst_n = 1'b0;
      a_d = 14'd5; a_esel = Rising_Edge; a_fsel = Delay; a_in = 1'b0;
      b_d = 4'd15; b_esel = Rising_Edge; b_fsel = One_Shot; b_in = 1'b0;
      repeat (2) tick();
      chk("rst out", 32'(a_out), 0);
      chk("rst busy", 32'(a_busy), 0);
      chk("rst count", 32'(a_count), 0);
      rst_n = 1'b1;
      repeat (2) tick();

      // Delay, rising, D=5: rise appears at cycle 6; fall passes through at cycle 1.
      a_in = 1'b1;
      for (int n = 1; n <= 7; n++) begin
         tick();
         chk("dly_r out", 32'(a_out), 32'(n >= 6));
         if (n <= 5) chk("dly_r count", 32'(a_count), 32'(n));
      end
      chk("dly_r busy_end", 32'(a_busy), 0);
      a_in = 1'b0;
      tick();
      chk("dly_r fall", 32'(a_out), 0);

      // Delay, both, D=8: a 3-cycle pulse is filtered.
      cfg(Delay, Both_Edge, 14'd8);
      a_in = 1'b1;
      repeat (3) tick();
      chk("dly_b busy", 32'(a_busy), 1);
      chk("dly_b count", 32'(a_count), 3);
      a_in = 1'b0;
      tick();
      chk("dly_b cancel_busy", 32'(a_busy), 0);
      chk("dly_b cancel_count", 32'(a_count), 0);
      repeat (8) tick();
      chk("dly_b out", 32'(a_out), 0);

      // One-shot, falling, D=3: second fall during the pulse is ignored.
      a_in = 1'b1;
      cfg(One_Shot, Falling_Edge, 14'd3);
      chk("os idle", 32'(a_out), 0);
      os_drv = 6'b000010;
      os_exp = 6'b001111;
      for (int n = 1; n <= 6; n++) begin
         a_in = os_drv[n-1];
         tick();
         chk("os_f out", 32'(a_out), 32'(os_exp[n-1]));
      end

      // Edge-detect, both, D=3: rise at 0, fall at 3 -> high cycles 1..7.
      cfg(Edge_Detect, Both_Edge, 14'd3);
      for (int n = 1; n <= 9; n++) begin
         a_in = (n <= 3);
         tick();
         chk("ed_b out", 32'(a_out), 32'(n <= 7));
      end

      // D=0 in each mode.
      a_in = 1'b0;
      cfg(Delay, Rising_Edge, 14'd0);
      a_in = 1'b1;
      tick();
      chk("d0 dly out", 32'(a_out), 1);
      chk("d0 dly busy", 32'(a_busy), 0);
      a_in = 1'b0;
      tick();
      chk("d0 dly fall", 32'(a_out), 0);
      cfg(One_Shot, Rising_Edge, 14'd0);
      a_in = 1'b1;
      tick();
      chk("d0 os out1", 32'(a_out), 1);
      chk("d0 os busy1", 32'(a_busy), 1);
      tick();
      chk("d0 os out2", 32'(a_out), 0);
      chk("d0 os busy2", 32'(a_busy), 0);
      a_in = 1'b0;
      cfg(Edge_Detect, Rising_Edge, 14'd0);
      a_in = 1'b1;
      tick();
      chk("d0 ed out1", 32'(a_out), 1);
      tick();
      chk("d0 ed out2", 32'(a_out), 0);

      // W=4, D=15 one-shot: 16-cycle pulse with no counter wrap.
      b_in = 1'b1;
      for (int n = 1; n <= 17; n++) begin
         tick();
         chk("wmax out", 32'(b_out), 32'(n <= 16));
         if (n == 16) chk("wmax count", 32'(b_count), 15);
      end
      chk("wmax busy", 32'(b_busy), 0);

      // Reset mid-RUN, release with i_in high.
      a_in = 1'b0;
      cfg(Delay, Rising_Edge, 14'd5);
      a_in = 1'b1;
      repeat (2) tick();
      chk("mrst busy_pre", 32'(a_busy), 1);
      rst_n = 1'b0;
      tick();
      chk("mrst out", 32'(a_out), 0);
      chk("mrst busy", 32'(a_busy), 0);
      chk("mrst count", 32'(a_count), 0);
      tick();
      rst_n = 1'b1;
      for (int n = 1; n <= 7; n++) begin
         tick();
         chk("mrst dly out", 32'(a_out), 32'(n >= 6));
         if (n == 1) chk("mrst dly busy", 32'(a_busy), 1);
      end

      // Function-select change mid-RUN aborts to IDLE.
      a_in = 1'b0;
      cfg(One_Shot, Rising_Edge, 14'd8);
      a_in = 1'b1;
      repeat (3) tick();
      chk("abort pre_out", 32'(a_out), 1);
      chk("abort pre_busy", 32'(a_busy), 1);
      a_fsel = Edge_Detect;
      tick();
      chk("abort out", 32'(a_out), 0);
      chk("abort busy", 32'(a_busy), 0);
      chk("abort count", 32'(a_count), 0);
      tick();
      chk("abort after", 32'(a_out), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dly_oneshot_macro.md
# dly_oneshot_macro

Parametrised, fully synchronous successor to the CNT0 delay-mode logic for the SLG46620 counter/delay macrocell model. One block covers three macrocell functions: delay (DLY), one-shot (OS) and edge-detect pulse (ED). Each function supports rising, falling or both-edge qualification and has its own internal counter. It sits behind the macrocell function multiplexer, and its o_out drives the macrocell output when any of these three functions is selected.

## Interface
- BIT_WIDTH, 14: width of counter and delay register (W).
- i_clk  in  1  reference clock; all state changes on posedge.
- i_reset_n  in  1  synchronous, active-low reset.
- i_data_from_register  in  W  delay/pulse count D.
- i_edge_reset_mode_select  in  2  edge select (Rising_Edge, Falling_Edge, Both_Edge).
- i_function_select  in  2  Delay, One_Shot, Edge_Detect; the reserved code behaves as Delay.
- i_in  in  1  macrocell input, synchronous to i_clk.
- o_out  out  1  registered macrocell output.
- o_busy  out  1  high while the counter is running (state RUN).
- o_count  out  W  current counter value.

## Operation
- Input register r_in samples i_in every cycle.
  - rise = i_in & ~r_in; fall = ~i_in & r_in.
  - Qualifying edge q is rise, fall or rise|fall, per the edge select.
- Two states: IDLE and RUN. Counter cnt saturates at D and never wraps.
- Delay mode:
  - IDLE, non-qualifying edge: o_out <= i_in.
  - IDLE, qualifying edge with D==0: o_out <= i_in.
  - IDLE, qualifying edge with D>0: target <= i_in, cnt <= 1, enter RUN.
  - RUN, i_in != target: cancel. Go to IDLE, cnt <= 0, o_out unchanged. This filters glitches shorter than D+1 cycles. Cancel takes priority over a qualifying edge in the same cycle, and no new delay starts.
  - RUN, cnt == D: o_out <= target, go to IDLE, cnt <= 0.
  - RUN, otherwise: cnt <= cnt+1.
- One-shot mode:
  - IDLE, qualifying edge: o_out <= 1, cnt <= 0, enter RUN.
  - RUN, cnt == D: o_out <= 0, go to IDLE.
  - RUN, otherwise: cnt++.
  - Edges during RUN are ignored (non-retriggerable), including an edge in the terminal cycle.
- Edge-detect mode: same as one-shot, except that a qualifying edge during RUN (terminal cycle included) reloads cnt <= 0 and o_out stays 1 (retriggerable).
- Configuration change:
  - Function select and edge select are registered. If either registered copy differs from its input, the block aborts to IDLE and cnt <= 0.
  - On abort, o_out <= i_in in Delay mode and o_out <= 0 otherwise.
- Reset (i_reset_n low at a posedge): state IDLE, cnt 0, r_in 0, target 0, o_out 0, o_busy 0, o_count 0. Reset mid-RUN discards the pending event.
- After reset release with i_in already high, a rise is detected on the first cycle and is processed normally.

## Timing
- Cycle 0 is the posedge at which i_in is first sampled at its new level.
- Non-delayed Delay-mode edge: o_out changes at cycle 1.
- Delayed edge: o_out changes at cycle D+1. D==0 gives the same latency as a non-delayed edge.
- OS/ED pulse: o_out is high from cycle 1 through cycle D+1, i.e. exactly D+1 cycles. A retrigger at cycle k extends the high time to cycle k+D+1.
- Delay-mode cancel window: the reverse transition must be sampled at cycles 1..D.
- o_busy is high from cycle 1 until the cycle after termination.
- Maximum D = 2^W-1 requires no wrap.

## Structure
- Additions to slg46620_cnt0_pkg:
  - typedef enum for function select: Delay, One_Shot, Edge_Detect.
  - typedef enum for state: IDLE, RUN.
  - Reuse the existing edge enum.
- One sub-module, edge_sel_detect: holds r_in, produces rise, fall and the qualified edge q for the given edge select.
- Counter and FSM live in the top module.

## Test plan
- Delay, Rising, D=5: i_in 0→1 at cycle 0 → o_out rises at cycle 6. Then 1→0 → o_out falls 1 cycle later.
- Delay, Both, D=8: high pulse of 3 cycles → o_out stays 0, o_busy drops, cnt returns to 0.
- One-shot, Falling, D=3: two falls 2 cycles apart → single 4-cycle pulse; second edge ignored.
- Edge-detect, Both, D=3: rise at 0, fall at 3 → o_out high cycles 1..7.
- D=0 in all modes: single-cycle pulse / 1-cycle latency. D=2^W-1 with W=4: 16-cycle pulse, no wrap.
- Reset asserted mid-RUN, then release with i_in=1 → all outputs 0 after reset; Delay mode produces a delayed rise at D+1 after release. Function-select change mid-RUN → abort to IDLE next cycle.
